// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states and default widths.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 32;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Counter width for a saturating count of 0..limit; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory port with one
// outstanding transaction and a starvation guard that forces an I grant after STARVE_LIMIT D wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_wen,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             grant_i, grant_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_MAX);

    // Grant selection, memory request forwarding, response routing and next state.
    // Everything is gated by rst so all outputs read zero while reset is held.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        mem_valid    = 1'b0;
        mem_addr     = '0;
        mem_wen      = 1'b0;
        mem_wdata    = '0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    // D is preferred unless I has waited out STARVE_LIMIT D grants.
                    if (i_valid && (!d_valid || starved)) begin
                        grant_i = 1'b1;
                    end else if (d_valid) begin
                        grant_d = 1'b1;
                    end

                    mem_valid = grant_i | grant_d;

                    if (grant_i) begin
                        mem_addr = i_addr;
                        i_ready  = mem_ready;
                        if (mem_ready) begin
                            state_d      = BUSY_I;
                            starve_cnt_d = '0;
                        end
                    end

                    if (grant_d) begin
                        mem_addr  = d_addr;
                        mem_wen   = d_wen;
                        mem_wdata = d_wdata;
                        d_ready   = mem_ready;
                        if (mem_ready) begin
                            state_d = BUSY_D;
                            if (!i_valid) begin
                                starve_cnt_d = '0;
                            end else if (!starved) begin
                                starve_cnt_d = starve_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end

                BUSY_I: begin
                    if (mem_rvalid) begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_rdata;
                        state_d  = IDLE;
                    end
                end

                BUSY_D: begin
                    if (mem_rvalid) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                        state_d  = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts accepted requests
// and responses into queues; a negedge monitor pops and compares what the DUT presents.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_ready, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_valid, d_ready, d_wen, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          is_i;
        logic [AW-1:0] addr;
        logic        wen;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        bit          is_i;
        logic [DW-1:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: who owns the memory (0 none, 1 fetch, 2 data) and how many
    // D grants in a row have been taken while a fetch was waiting.
    int m_owner  = 0;
    int m_starve = 0;
    bit exp_rst       = 1'b1;
    bit exp_mem_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the model then records what the DUT must do for it.
    task automatic cycle(input bit r, input bit iv, input logic [AW-1:0] ia,
                         input bit dv, input logic [AW-1:0] da, input bit dw,
                         input logic [DW-1:0] dd, input bit mr, input bit mrv,
                         input logic [DW-1:0] mrd);
        bit   pick_i;
        req_t rq;
        rsp_t rs;
        @(posedge clk);
        #1;
        rst = r; i_valid = iv; i_addr = ia;
        d_valid = dv; d_addr = da; d_wen = dw; d_wdata = dd;
        mem_ready = mr; mem_rvalid = mrv; mem_rdata = mrd;
        #1;
        exp_rst       = r;
        exp_mem_valid = 1'b0;
        if (r) begin
            m_owner  = 0;
            m_starve = 0;
        end else if (m_owner == 0) begin
            pick_i        = iv && (!dv || m_starve >= LIMIT);
            exp_mem_valid = iv || dv;
            if ((iv || dv) && mr) begin
                if (pick_i) begin
                    rq = '{1'b1, ia, 1'b0, '0};
                    m_owner  = 1;
                    m_starve = 0;
                end else begin
                    rq = '{1'b0, da, dw, dd};
                    m_owner  = 2;
                    m_starve = iv ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
                end
                req_q.push_back(rq);
            end
        end else if (mrv) begin
            rs = '{(m_owner == 1), mrd};
            rsp_q.push_back(rs);
            m_owner = 0;
        end
    endtask

    // Monitor: compares DUT outputs against the model's expectations every negedge.
    initial begin : monitor
        req_t e;
        rsp_t s;
        forever begin
            @(negedge clk);
            if (exp_rst) begin
                chk("rst_flags", 64'({i_ready, d_ready, i_rvalid, d_rvalid, mem_valid, mem_wen}), 64'd0);
                chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
                chk("rst_mem_payload", 64'({mem_addr, mem_wdata}), 64'd0);
            end else begin
                chk("mem_valid", 64'(mem_valid), 64'(exp_mem_valid));
                if (mem_valid && mem_ready) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_accept", 64'd1, 64'd0);
                    end else begin
                        e = req_q.pop_front();
                        chk("grant_i_ready", 64'(i_ready), 64'(e.is_i));
                        chk("grant_d_ready", 64'(d_ready), 64'(!e.is_i));
                        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                        chk("mem_wen", 64'(mem_wen), 64'(e.wen));
                        chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end else begin
                    chk("idle_readies", 64'({i_ready, d_ready}), 64'd0);
                end
                if (i_rvalid || d_rvalid) begin
                    chk("rvalid_onehot", 64'(i_rvalid && d_rvalid), 64'd0);
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rvalid", 64'd1, 64'd0);
                    end else begin
                        s = rsp_q.pop_front();
                        chk("rsp_target_i", 64'(i_rvalid), 64'(s.is_i));
                        chk("rsp_data", 64'(s.is_i ? i_rdata : d_rdata), 64'(s.data));
                    end
                end
                if (!i_rvalid) chk("i_rdata_zero", 64'(i_rdata), 64'd0);
                if (!d_rvalid) chk("d_rdata_zero", 64'(d_rdata), 64'd0);
            end
        end
    end

    initial begin : stim
        bit            iv, dv, mr, mrv, r;
        int            p_valid;
        rst = 1'b1; i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_wen = 0;
        d_wdata = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;

        repeat (2) cycle(1, 0, '0, 0, '0, 0, '0, 0, 0, '0);

        // Lone fetch, memory ready, response the next cycle.
        cycle(0, 1, 32'h100, 0, '0, 0, '0, 1, 0, '0);
        cycle(0, 0, '0, 0, '0, 0, '0, 1, 1, 32'hDEADBEEF);

        // Simultaneous requests: data write first, fetch on the next idle.
        cycle(0, 1, 32'h104, 1, 32'h200, 1, 32'h55, 1, 0, '0);
        cycle(0, 1, 32'h104, 0, '0, 0, '0, 1, 1, 32'h0);
        cycle(0, 1, 32'h104, 0, '0, 0, '0, 1, 0, '0);
        cycle(0, 0, '0, 0, '0, 0, '0, 1, 1, 32'h1234);

        // Both held continuously: four D grants, one I, then D again.
        for (int k = 0; k < 24; k++) begin
            cycle(0, 1, 32'h300 + AW'(k), 1, 32'h400 + AW'(k), k[0], DW'(k), 1,
                  (m_owner != 0), DW'($urandom));
        end
        while (m_owner != 0) cycle(0, 0, '0, 0, '0, 0, '0, 0, 1, 32'h77);

        // Memory stalls three cycles with a data request pending, accepts on the fourth.
        repeat (3) cycle(0, 0, '0, 1, 32'h500, 0, '0, 0, 0, '0);
        cycle(0, 0, '0, 1, 32'h500, 0, '0, 1, 0, '0);
        cycle(0, 0, '0, 0, '0, 0, '0, 0, 1, 32'hCAFE);

        // Reset while a fetch is outstanding; the late response must be ignored.
        cycle(0, 1, 32'h600, 0, '0, 0, '0, 1, 0, '0);
        cycle(1, 0, '0, 0, '0, 0, '0, 0, 0, '0);
        cycle(0, 0, '0, 0, '0, 0, '0, 0, 1, 32'hBAD);

        // Stray memory response while idle.
        cycle(0, 0, '0, 0, '0, 0, '0, 0, 1, 32'hBAD2);
        cycle(0, 0, '0, 0, '0, 0, '0, 0, 0, '0);

        // Randomized traffic, alternating light and saturating request phases.
        for (int n = 0; n < 3000; n++) begin
            p_valid = ((n / 200) % 2 == 1) ? 95 : 45;
            r   = ($urandom_range(0, 99) < 2);
            iv  = ($urandom_range(0, 99) < p_valid);
            dv  = ($urandom_range(0, 99) < p_valid);
            mr  = ($urandom_range(0, 99) < 70);
            mrv = (m_owner != 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
            cycle(r, iv, AW'($urandom), dv, AW'($urandom), 1'($urandom), DW'($urandom),
                  mr, mrv, DW'($urandom));
        end

        cycle(0, 0, '0, 0, '0, 0, '0, 0, (m_owner != 0), 32'h99);
        repeat (2) cycle(0, 0, '0, 0, '0, 0, '0, 0, 0, '0);

        chk("req_queue_drained", 64'(req_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
